trap_ctrl: RTL and testbench

// Machine-mode trap sequencer between the pipeline and the CSR file. Arbitrates

---
 rtl/trap_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer between the pipeline and the CSR file.
// Arbitrates sync exceptions, MRET and the three M-mode interrupt lines, then
// performs the CSR save/restore as a fixed sequence of single CSR writes.
// It stalls and flushes the pipeline and redirects the PC to mtvec or mepc.
//
// Ports:
//   clk_i, rst_n_i                      clock, synchronous active-low reset
//   inst_valid_i, inst_addr_i           uncommitted instruction and its PC
//   ecall_i, ebreak_i, illegal_i        exception flags, qualified by inst_valid_i
//   mret_i                              MRET at the same stage
//   irq_ext_i, irq_sw_i, irq_timer_i    level-sensitive pending interrupt lines
//   mstatus_i, mie_i, mtvec_i, mepc_i   live CSR values
//   csr_we_o, csr_waddr_o, csr_wdata_o  CSR write port (addr/data 0 when idle)
//   stall_o, flush_o                    pipeline hold / kill younger instructions
//   jump_o, jump_addr_o                 one-cycle PC redirect and its target
module trap_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      inst_valid_i,
  input  logic [ADDR_WIDTH-1:0]     inst_addr_i,
  input  logic                      ecall_i,
  input  logic                      ebreak_i,
  input  logic                      illegal_i,
  input  logic                      mret_i,
  input  logic                      irq_ext_i,
  input  logic                      irq_sw_i,
  input  logic                      irq_timer_i,
  input  logic [DATA_WIDTH-1:0]     mstatus_i,
  input  logic [DATA_WIDTH-1:0]     mie_i,
  input  logic [DATA_WIDTH-1:0]     mtvec_i,
  input  logic [ADDR_WIDTH-1:0]     mepc_i,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      stall_o,
  output logic                      flush_o,
  output logic                      jump_o,
  output logic [ADDR_WIDTH-1:0]     jump_addr_o
);

  localparam logic [CSR_ADDR_WIDTH-1:0] CsrMstatus = CSR_ADDR_WIDTH'(12'h300);
  localparam logic [CSR_ADDR_WIDTH-1:0] CsrMepc    = CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] CsrMcause  = CSR_ADDR_WIDTH'(12'h342);

  typedef enum logic [2:0] {
    StIdle,
    StSaveEpc,
    StSaveCause,
    StSaveStatus,
    StTrapJump,
    StRestoreStatus,
    StRetJump
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [4:0]            code_q;
  logic                  irq_q;

  logic                  mei, msi, mti;
  logic                  exc_take, mret_take, irq_take, accept;
  logic [4:0]            exc_code, irq_code;
  logic [DATA_WIDTH-1:0] status_trap, status_mret, cause_word;
  logic [ADDR_WIDTH-1:0] tvec_base, trap_target, ret_target;
  logic                  unused_bits;

  // Only mie bits 11/3/7 and mepc[31:1] matter here.
  assign unused_bits = ^{mie_i, mepc_i[0]};

  always_comb begin
    mei       = irq_ext_i   & mie_i[11];
    msi       = irq_sw_i    & mie_i[3];
    mti       = irq_timer_i & mie_i[7];
    exc_take  = inst_valid_i & (illegal_i | ebreak_i | ecall_i);
    mret_take = inst_valid_i & mret_i;
    irq_take  = inst_valid_i & mstatus_i[3] & (mei | msi | mti);
    // Gated by reset so nothing is asserted while reset is held.
    accept    = rst_n_i & (state_q == StIdle) & (exc_take | mret_take | irq_take);
    exc_code  = illegal_i ? 5'd2 : (ebreak_i ? 5'd3 : 5'd11);
    irq_code  = mei ? 5'd11 : (msi ? 5'd3 : 5'd7);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      pc_q    <= '0;
      code_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (exc_take) begin
            state_q <= StSaveEpc;
            pc_q    <= inst_addr_i;
            code_q  <= exc_code;
            irq_q   <= 1'b0;
          end else if (mret_take) begin
            state_q <= StRestoreStatus;
          end else if (irq_take) begin
            state_q <= StSaveEpc;
            pc_q    <= inst_addr_i;
            code_q  <= irq_code;
            irq_q   <= 1'b1;
          end
        end
        StSaveEpc:       state_q <= StSaveCause;
        StSaveCause:     state_q <= StSaveStatus;
        StSaveStatus:    state_q <= StTrapJump;
        StRestoreStatus: state_q <= StRetJump;
        default:         state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    status_trap          = mstatus_i;
    status_trap[7]       = mstatus_i[3];
    status_trap[3]       = 1'b0;
    status_trap[12:11]   = 2'b11;
    status_mret          = mstatus_i;
    status_mret[3]       = mstatus_i[7];
    status_mret[7]       = 1'b1;
    status_mret[12:11]   = 2'b11;
    cause_word           = '0;
    cause_word[DATA_WIDTH-1] = irq_q;
    cause_word[4:0]      = code_q;
    tvec_base            = {mtvec_i[ADDR_WIDTH-1:2], 2'b00};
    // Vectored mode only offsets interrupts; the add wraps naturally.
    trap_target          = tvec_base + ((irq_q && mtvec_i[1:0] == 2'b01) ?
                                        ADDR_WIDTH'({code_q, 2'b00}) : '0);
    ret_target           = {mepc_i[ADDR_WIDTH-1:1], 1'b0};
  end

  always_comb begin
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    stall_o     = accept;
    flush_o     = 1'b0;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    case (state_q)
      StSaveEpc: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CsrMepc;
        csr_wdata_o = DATA_WIDTH'(pc_q);
      end
      StSaveCause: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CsrMcause;
        csr_wdata_o = cause_word;
      end
      StSaveStatus: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CsrMstatus;
        csr_wdata_o = status_trap;
      end
      StRestoreStatus: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CsrMstatus;
        csr_wdata_o = status_mret;
      end
      StTrapJump: begin
        stall_o     = 1'b0;
        flush_o     = 1'b1;
        jump_o      = 1'b1;
        jump_addr_o = trap_target;
      end
      StRetJump: begin
        stall_o     = 1'b0;
        flush_o     = 1'b1;
        jump_o      = 1'b1;
        jump_addr_o = ret_target;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid, ecall, ebreak, illegal, mret, irq_ext, irq_sw, irq_timer;
  logic [31:0] inst_addr, mstatus, mie, mtvec, mepc;
  logic        csr_we, stall, flush, jump;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, jump_addr;

  int total = 0;
  int bad   = 0;

  trap_ctrl dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .inst_valid_i (inst_valid),
    .inst_addr_i  (inst_addr),
    .ecall_i      (ecall),
    .ebreak_i     (ebreak),
    .illegal_i    (illegal),
    .mret_i       (mret),
    .irq_ext_i    (irq_ext),
    .irq_sw_i     (irq_sw),
    .irq_timer_i  (irq_timer),
    .mstatus_i    (mstatus),
    .mie_i        (mie),
    .mtvec_i      (mtvec),
    .mepc_i       (mepc),
    .csr_we_o     (csr_we),
    .csr_waddr_o  (csr_waddr),
    .csr_wdata_o  (csr_wdata),
    .stall_o      (stall),
    .flush_o      (flush),
    .jump_o       (jump),
    .jump_addr_o  (jump_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit v, ec, eb, il, mr, ext, sw, tm;
    logic [31:0] ms, mie, mtvec, pc, mepc;
  } stim_t;

  // kind: 0 = nothing taken, 1 = trap, 2 = mret
  typedef struct {
    int          kind;
    logic [31:0] cause, status, target;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(bit v, bit ec, bit eb, bit il, bit mr, bit ext, bit sw, bit tm,
                               logic [31:0] ms, logic [31:0] ie, logic [31:0] tv,
                               logic [31:0] pc, logic [31:0] ep);
    stim_t s;
    s.v = v; s.ec = ec; s.eb = eb; s.il = il; s.mr = mr;
    s.ext = ext; s.sw = sw; s.tm = tm;
    s.ms = ms; s.mie = ie; s.mtvec = tv; s.pc = pc; s.mepc = ep;
    return s;
  endfunction

  function automatic exp_t mke(int kind, logic [31:0] cause, logic [31:0] st, logic [31:0] tg);
    exp_t e;
    e.kind = kind; e.cause = cause; e.status = st; e.target = tg;
    return e;
  endfunction

  // Reference model: decides the outcome of one event from the architectural rules.
  function automatic exp_t model(stim_t s);
    exp_t e;
    int   codes[3];
    bit   pend[3];
    bit   is_irq;
    int   code;
    codes = '{11, 3, 7};
    pend  = '{s.ext, s.sw, s.tm};
    e = mke(0, 0, 0, 0);
    is_irq = 0;
    code = 0;
    if (s.v && (s.il || s.eb || s.ec)) begin
      e.kind = 1;
      code = s.il ? 2 : (s.eb ? 3 : 11);
    end else if (s.v && s.mr) begin
      e.kind = 2;
    end else if (s.v && s.ms[3]) begin
      for (int i = 0; i < 3; i++) begin
        if (e.kind == 0 && pend[i] && s.mie[codes[i]]) begin
          e.kind = 1;
          is_irq = 1;
          code = codes[i];
        end
      end
    end
    if (e.kind == 1) begin
      e.cause  = is_irq ? 32'h8000_0000 + 32'(code) : 32'(code);
      e.status = (s.ms & ~32'h1888) | (s.ms[3] ? 32'h80 : 32'h0) | 32'h1800;
      e.target = (s.mtvec & ~32'h3) +
                 ((is_irq && s.mtvec[1:0] == 2'b01) ? 32'(4 * code) : 32'h0);
    end else if (e.kind == 2) begin
      e.status = (s.ms & ~32'h1888) | (s.ms[7] ? 32'h8 : 32'h0) | 32'h1880;
      e.target = s.mepc & ~32'h1;
    end
    return e;
  endfunction

  task automatic drive(input stim_t s);
    inst_valid = s.v; ecall = s.ec; ebreak = s.eb; illegal = s.il; mret = s.mr;
    irq_ext = s.ext; irq_sw = s.sw; irq_timer = s.tm;
    mstatus = s.ms; mie = s.mie; mtvec = s.mtvec; inst_addr = s.pc; mepc = s.mepc;
  endtask

  task automatic clear_events();
    inst_valid = 0; ecall = 0; ebreak = 0; illegal = 0; mret = 0;
    irq_ext = 0; irq_sw = 0; irq_timer = 0;
  endtask

  // Present one event for a single cycle from IDLE and observe the following six cycles.
  task automatic run_case(input stim_t s, input exp_t e, input string tag);
    logic [11:0] wa[4];
    logic [31:0] wd[4];
    int          n, jat, jcyc, bogus, nexp;
    logic [31:0] jaddr;
    logic        jflush;
    n = 0; jat = -1; bogus = 0; jaddr = 0; jflush = 0;
    for (int i = 0; i < 4; i++) begin wa[i] = 0; wd[i] = 0; end
    jcyc = (e.kind == 1) ? 4 : ((e.kind == 2) ? 2 : 0);
    nexp = (e.kind == 1) ? 3 : ((e.kind == 2) ? 1 : 0);
    @(negedge clk);
    drive(s);
    #1;
    check({tag, " stall@accept"}, 32'(stall), 32'(e.kind != 0));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      clear_events();
      #1;
      check($sformatf("%s stall@%0d", tag, k), 32'(stall), 32'((e.kind != 0) && k < jcyc));
      if (csr_we) begin
        if (n < 4) begin wa[n] = csr_waddr; wd[n] = csr_wdata; end
        n++;
      end else if (csr_waddr != 0 || csr_wdata != 0) begin
        bogus++;
      end
      if (jump) begin
        if (jat < 0) jat = k;
        jaddr = jump_addr;
        jflush = flush;
        if (csr_we) bogus++;
      end else if (flush) begin
        bogus++;
      end
    end
    check({tag, " nwrites"}, 32'(n), 32'(nexp));
    if (e.kind == 1) begin
      check({tag, " w0 addr"}, 32'(wa[0]), 32'h341);
      check({tag, " w0 data"}, wd[0], s.pc);
      check({tag, " w1 addr"}, 32'(wa[1]), 32'h342);
      check({tag, " w1 data"}, wd[1], e.cause);
      check({tag, " w2 addr"}, 32'(wa[2]), 32'h300);
      check({tag, " w2 data"}, wd[2], e.status);
    end else if (e.kind == 2) begin
      check({tag, " w0 addr"}, 32'(wa[0]), 32'h300);
      check({tag, " w0 data"}, wd[0], e.status);
    end
    check({tag, " jump cycle"}, 32'(jat), (e.kind == 0) ? 32'hFFFF_FFFF : 32'(jcyc));
    if (e.kind != 0) begin
      check({tag, " jump addr"}, jaddr, e.target);
      check({tag, " flush@jump"}, 32'(jflush), 32'h1);
    end
    check({tag, " stray outputs"}, 32'(bogus), 32'h0);
  endtask

  vec_t vecs[12];

  initial begin
    int    quiet;
    stim_t s;
    exp_t  e;

    vecs[0]  = '{mk(1,1,0,0,0,0,0,0, 32'h8, 32'h0, 32'h800, 32'h100, 32'h0),
                 mke(1, 32'd11, 32'h1880, 32'h800)};
    vecs[1]  = '{mk(1,0,0,0,0,1,0,1, 32'h8, 32'h880, 32'h801, 32'h200, 32'h0),
                 mke(1, 32'h8000_000B, 32'h1880, 32'h82C)};
    vecs[2]  = '{mk(1,0,0,0,0,0,0,1, 32'h0, 32'h880, 32'h801, 32'h204, 32'h0),
                 mke(0, 0, 0, 0)};
    vecs[3]  = '{mk(1,0,0,0,0,0,0,1, 32'h8, 32'h800, 32'h801, 32'h208, 32'h0),
                 mke(0, 0, 0, 0)};
    vecs[4]  = '{mk(1,0,0,0,1,0,0,0, 32'h1880, 32'h0, 32'h800, 32'h20C, 32'h203),
                 mke(2, 0, 32'h1888, 32'h202)};
    vecs[5]  = '{mk(1,1,1,0,0,0,0,0, 32'h0, 32'h0, 32'h801, 32'h44, 32'h0),
                 mke(1, 32'd3, 32'h1800, 32'h800)};
    vecs[6]  = '{mk(1,0,0,0,0,0,1,1, 32'h8, 32'h888, 32'h1001, 32'h48, 32'h0),
                 mke(1, 32'h8000_0003, 32'h1880, 32'h100C)};
    vecs[7]  = '{mk(0,1,0,0,0,0,0,0, 32'h8, 32'h0, 32'h800, 32'h4C, 32'h0),
                 mke(0, 0, 0, 0)};
    vecs[8]  = '{mk(1,1,0,0,1,0,0,0, 32'h1880, 32'h0, 32'h800, 32'h50, 32'h203),
                 mke(1, 32'd11, 32'h1800, 32'h800)};
    vecs[9]  = '{mk(0,0,0,0,0,1,0,0, 32'h8, 32'h800, 32'h800, 32'h54, 32'h0),
                 mke(0, 0, 0, 0)};
    vecs[10] = '{mk(1,0,1,1,0,0,0,0, 32'hFFFF_FFFF, 32'h0, 32'h7FC, 32'h58, 32'h0),
                 mke(1, 32'd2, 32'hFFFF_FFF7, 32'h7FC)};
    vecs[11] = '{mk(1,0,0,0,0,1,0,0, 32'h8, 32'h800, 32'hFFFF_FFF1, 32'h5C, 32'h0),
                 mke(1, 32'h8000_000B, 32'h1880, 32'h1C)};

    rst_n = 0;
    clear_events();
    inst_addr = 0; mstatus = 0; mie = 0; mtvec = 0; mepc = 0;
    repeat (3) @(negedge clk);
    check("reset we", 32'(csr_we), 0);
    check("reset stall/flush/jump", {29'd0, stall, flush, jump}, 0);
    check("reset addr/data", 32'(csr_waddr) | csr_wdata | jump_addr, 0);
    rst_n = 1;

    for (int i = 0; i < 12; i++) run_case(vecs[i].s, vecs[i].e, $sformatf("vec%0d", i));

    // Masked timer interrupt: nothing may happen for 20 cycles.
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      drive(mk(1,0,0,0,0,0,0,1, (m == 0) ? 32'h0 : 32'h8, (m == 0) ? 32'h880 : 32'h808,
               32'h800, 32'h60, 32'h0));
      quiet = 0;
      for (int k = 0; k < 20; k++) begin
        #1;
        if (stall || csr_we || jump || flush) quiet++;
        @(negedge clk);
      end
      check($sformatf("masked irq%0d activity", m), 32'(quiet), 0);
      clear_events();
    end

    // Exception beats a simultaneous interrupt; the interrupt waits for MRET.
    s = mk(1,0,0,1,0,1,0,0, 32'h8, 32'h800, 32'h800, 32'h70, 32'h74);
    run_case(s, mke(1, 32'd2, 32'h1880, 32'h800), "ill+irq");
    s.il = 0; s.ms = model(mk(1,0,0,1,0,0,0,0, 32'h8, 0, 0, 0, 0)).status;
    run_case(s, model(s), "irq masked after trap");
    s.mr = 1;
    e = model(s);
    run_case(s, e, "mret reenable");
    s.mr = 0; s.ms = e.status;
    run_case(s, mke(1, 32'h8000_000B, 32'h1880, 32'h800), "irq after mret");

    // Random events against the reference model.
    for (int i = 0; i < 80; i++) begin
      s = mk($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
             $urandom & 32'h888, $urandom, $urandom, $urandom);
      run_case(s, model(s), $sformatf("rnd%0d", i));
    end

    // Reset while SAVE_CAUSE is on the write port.
    @(negedge clk);
    drive(mk(1,1,0,0,0,0,0,0, 32'h8, 32'h0, 32'h800, 32'h300, 32'h0));
    @(negedge clk);
    clear_events();
    #1;
    check("rst seq epc addr", 32'(csr_waddr), 32'h341);
    @(negedge clk);
    #1;
    check("rst seq cause addr", 32'(csr_waddr), 32'h342);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rst seq outputs", {28'd0, csr_we, stall, flush, jump}, 0);
    check("rst seq addr/data", 32'(csr_waddr) | csr_wdata | jump_addr, 0);
    quiet = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (csr_we || jump || stall) quiet++;
    end
    check("rst seq no further activity", 32'(quiet), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
